// File: rtl/if_fetch_unit_if.sv
// Instruction bus between the fetch unit (master) and the instruction memory (slave).
// Single outstanding word read: BusReq/BusAddr held until BusAck returns BusRdData.
interface if_fetch_unit_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              BusReq;
    logic [ADDR_W-1:0] BusAddr;
    logic              BusAck;
    logic [DATA_W-1:0] BusRdData;

    modport master (
        output BusReq,
        output BusAddr,
        input  BusAck,
        input  BusRdData
    );

    modport slave (
        input  BusReq,
        input  BusAddr,
        output BusAck,
        output BusRdData
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: single-outstanding bus reads into a prefetch FIFO feeding the IF register.
// Optional IF_FETCH_PERF_EN adds saturating fetch-stall and dropped-ack counters.
module if_fetch_unit #(
    parameter int                ADDR_W   = 30,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
    parameter logic [DATA_W-1:0] NOP_INSN = 32'h0
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] NewPC,
    input  logic              BrTaken,
    input  logic [ADDR_W-1:0] BrAddr,
    if_fetch_unit_if.master   bus,
    output logic [DATA_W-1:0] Insn,
    output logic [ADDR_W-1:0] InsnPC,
    output logic              InsnValid,
    output logic              FetchStall
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]       PerfStallCnt,
    output logic [31:0]       PerfDropCnt
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] bus_addr, bus_addr_nxt;
    logic [ADDR_W-1:0] held_tgt, held_tgt_nxt;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              redirect;
    logic              bus_req;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] mem_insn [DEPTH];
    logic [ADDR_W-1:0] mem_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              empty, full;

    assign wr_idx = wr_ptr[IDX_W-1:0];
    assign rd_idx = rd_ptr[IDX_W-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);

    assign redirect     = Flush | BrTaken;
    assign redirect_tgt = Flush ? NewPC : BrAddr;
    assign pop          = ~empty & ~Stall & ~redirect;

    always_ff @(posedge clk) begin
        if (reset_) begin
            state    <= IDLE;
            bus_addr <= RESET_PC;
            held_tgt <= RESET_PC;
        end else begin
            state    <= state_nxt;
            bus_addr <= bus_addr_nxt;
            held_tgt <= held_tgt_nxt;
        end
    end

    // A request already on the bus cannot be withdrawn, so a redirect without
    // the ack parks the target in held_tgt and lets DROP swallow the stale data.
    always_comb begin
        state_nxt    = state;
        bus_addr_nxt = bus_addr;
        held_tgt_nxt = held_tgt;
        bus_req      = 1'b0;
        push         = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = FETCH;
                if (redirect) bus_addr_nxt = redirect_tgt;
            end
            FETCH: begin
                bus_req = ~full | pop;
                if (redirect) begin
                    if (bus_req && !bus.BusAck) begin
                        held_tgt_nxt = redirect_tgt;
                        state_nxt    = DROP;
                    end else begin
                        bus_addr_nxt = redirect_tgt;
                    end
                end else if (bus_req && bus.BusAck) begin
                    push         = 1'b1;
                    bus_addr_nxt = bus_addr + ADDR_W'(1);
                end
            end
            DROP: begin
                bus_req = 1'b1;
                if (redirect) held_tgt_nxt = redirect_tgt;
                if (bus.BusAck) begin
                    bus_addr_nxt = redirect ? redirect_tgt : held_tgt;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_ || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_insn[wr_idx] <= bus.BusRdData;
            mem_pc[wr_idx]   <= bus_addr;
        end
    end

    assign bus.BusReq  = bus_req;
    assign bus.BusAddr = bus_addr;

    assign InsnValid  = ~empty;
    assign FetchStall = empty;
    assign Insn       = empty ? NOP_INSN : mem_insn[rd_idx];
    assign InsnPC     = empty ? bus_addr : mem_pc[rd_idx];

`ifdef IF_FETCH_PERF_EN
    logic drop_ack;

    // Any ack that does not push is a discarded fetch: DROP, or FETCH with a same-cycle redirect.
    assign drop_ack = bus.BusAck &&
                      ((state == DROP) || ((state == FETCH) && redirect && bus_req));

    always_ff @(posedge clk) begin
        if (reset_) begin
            PerfStallCnt <= '0;
            PerfDropCnt  <= '0;
        end else begin
            if (empty && (PerfStallCnt != 32'hFFFF_FFFF))
                PerfStallCnt <= PerfStallCnt + 32'd1;
            if (drop_ack && (PerfDropCnt != 32'hFFFF_FFFF))
                PerfDropCnt <= PerfDropCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit: sequential fetch, FIFO fill/drain,
// branch and flush redirects, dropped acks, address wrap and reset mid-request.
module tb_if_fetch_unit;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset_;
    logic              Stall;
    logic              Flush;
    logic [ADDR_W-1:0] NewPC;
    logic              BrTaken;
    logic [ADDR_W-1:0] BrAddr;
    logic [DATA_W-1:0] Insn;
    logic [ADDR_W-1:0] InsnPC;
    logic              InsnValid;
    logic              FetchStall;
`ifdef IF_FETCH_PERF_EN
    logic [31:0]       PerfStallCnt;
    logic [31:0]       PerfDropCnt;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int pushes;

    if_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    if_fetch_unit #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .Stall      (Stall),
        .Flush      (Flush),
        .NewPC      (NewPC),
        .BrTaken    (BrTaken),
        .BrAddr     (BrAddr),
        .bus        (bus.master),
        .Insn       (Insn),
        .InsnPC     (InsnPC),
        .InsnValid  (InsnValid),
        .FetchStall (FetchStall)
`ifdef IF_FETCH_PERF_EN
        ,
        .PerfStallCnt (PerfStallCnt),
        .PerfDropCnt  (PerfDropCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mkData(input logic [ADDR_W-1:0] a);
        return 32'h1000_0000 + {2'b00, a};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    endtask

    // Inputs change 1 time unit after the active edge; outputs are sampled after a further settle.
    task automatic applyStimulus(input logic stall, input logic flush, input logic [ADDR_W-1:0] newPc,
                                 input logic br, input logic [ADDR_W-1:0] brAddr,
                                 input logic ack, input logic [DATA_W-1:0] data);
        Stall         = stall;
        Flush         = flush;
        NewPC         = newPc;
        BrTaken       = br;
        BrAddr        = brAddr;
        bus.BusAck    = ack;
        bus.BusRdData = data;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ = 1'b1;
        applyStimulus(0, 0, '0, 0, '0, 0, '0);
        step();
        step();
        checkOutput("rst_busreq", bus.BusReq, 0);
        checkOutput("rst_busaddr", bus.BusAddr, 0);
        checkOutput("rst_valid", InsnValid, 0);
        checkOutput("rst_insn", Insn, 0);
        checkOutput("rst_pc", InsnPC, 0);
        checkOutput("rst_fstall", FetchStall, 1);

        // Sequential fetch, slave acks one cycle after each request.
        reset_ = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_req", bus.BusReq, 1);
            checkOutput("t1_addr", bus.BusAddr, i);
            if (i > 0) begin
                checkOutput("t1_valid", InsnValid, 1);
                checkOutput("t1_insn", Insn, mkData(ADDR_W'(i - 1)));
                checkOutput("t1_pc", InsnPC, i - 1);
            end
            applyStimulus(0, 0, '0, 0, '0, 0, '0);
            step();
            checkOutput("t1_empty", InsnValid, 0);
            applyStimulus(0, 0, '0, 0, '0, 1, mkData(ADDR_W'(i)));
            step();
        end
        checkOutput("t1_valid3", InsnValid, 1);
        checkOutput("t1_insn3", Insn, mkData(30'd3));
        checkOutput("t1_pc3", InsnPC, 3);
        checkOutput("t1_fstall", FetchStall, 0);
        applyStimulus(0, 0, '0, 0, '0, 0, '0);
        step();

        // Stalled pipeline with an always-acking slave fills exactly DEPTH entries.
        pushes = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1, 0, '0, 0, '0, 1, mkData(bus.BusAddr));
            if (bus.BusReq) pushes++;
            step();
        end
        checkOutput("t2_pushes", pushes, DEPTH);
        checkOutput("t2_req_full", bus.BusReq, 0);
        checkOutput("t2_addr_full", bus.BusAddr, 8);
        checkOutput("t2_head", Insn, mkData(30'd4));
        applyStimulus(0, 0, '0, 0, '0, 1, mkData(bus.BusAddr));
        checkOutput("t2_req_pop", bus.BusReq, 1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t2_pop_insn", Insn, mkData(ADDR_W'(4 + k)));
            checkOutput("t2_pop_pc", InsnPC, 4 + k);
            applyStimulus(0, 0, '0, 0, '0, 1, mkData(bus.BusAddr));
            step();
        end
        applyStimulus(1, 0, '0, 0, '0, 0, '0);
        checkOutput("t2_refull_req", bus.BusReq, 0);
        checkOutput("t2_refull_pc", InsnPC, 8);

        // Branch while full and idle on the bus.
        applyStimulus(1, 0, '0, 1, 30'h100, 0, '0);
        step();
        checkOutput("t3_valid", InsnValid, 0);
        checkOutput("t3_fstall", FetchStall, 1);
        checkOutput("t3_req", bus.BusReq, 1);
        checkOutput("t3_addr", bus.BusAddr, 30'h100);

        // Flush beats branch with a request pending; ack arrives three cycles later.
        applyStimulus(0, 1, 30'h40, 1, 30'h80, 0, '0);
        step();
        checkOutput("t4_req", bus.BusReq, 1);
        checkOutput("t4_addr_hold", bus.BusAddr, 30'h100);
        checkOutput("t4_valid", InsnValid, 0);
        applyStimulus(0, 0, '0, 0, '0, 0, '0);
        step();
        checkOutput("t4_addr_hold2", bus.BusAddr, 30'h100);
        step();
        applyStimulus(0, 0, '0, 0, '0, 1, 32'hDEAD_BEEF);
        step();
        checkOutput("t4_addr_tgt", bus.BusAddr, 30'h40);
        checkOutput("t4_req_tgt", bus.BusReq, 1);
        checkOutput("t4_not_pushed", InsnValid, 0);
`ifdef IF_FETCH_PERF_EN
        checkOutput("t4_perf_drop", PerfDropCnt, 1);
`endif
        applyStimulus(0, 0, '0, 0, '0, 1, mkData(30'h40));
        step();
        checkOutput("t4_valid_tgt", InsnValid, 1);
        checkOutput("t4_insn_tgt", Insn, mkData(30'h40));
        checkOutput("t4_pc_tgt", InsnPC, 30'h40);
        checkOutput("t4_addr_next", bus.BusAddr, 30'h41);

        // Flush with same-cycle ack, then fetch across the top of the address space.
        applyStimulus(0, 1, 30'h3FFF_FFFF, 0, '0, 1, mkData(30'h41));
        step();
        checkOutput("t5_addr_top", bus.BusAddr, 30'h3FFF_FFFF);
        checkOutput("t5_req", bus.BusReq, 1);
        checkOutput("t5_valid", InsnValid, 0);
`ifdef IF_FETCH_PERF_EN
        checkOutput("t5_perf_drop", PerfDropCnt, 2);
`endif
        applyStimulus(0, 0, '0, 0, '0, 1, mkData(30'h3FFF_FFFF));
        step();
        checkOutput("t5_addr_wrap", bus.BusAddr, 0);
        checkOutput("t5_pc_top", InsnPC, 30'h3FFF_FFFF);
        checkOutput("t5_insn_top", Insn, 32'h4FFF_FFFF);
        applyStimulus(0, 0, '0, 0, '0, 1, mkData(30'h0));
        step();
        checkOutput("t5_pc_zero", InsnPC, 0);
        checkOutput("t5_insn_zero", Insn, 32'h1000_0000);
        checkOutput("t5_addr_one", bus.BusAddr, 1);

        // Reset while a request is outstanding, then a stray ack in IDLE.
        applyStimulus(0, 0, '0, 0, '0, 0, '0);
        step();
        reset_ = 1'b1;
        applyStimulus(0, 0, '0, 0, '0, 0, '0);
        checkOutput("t6_pending", bus.BusReq, 1);
        step();
        checkOutput("t6_req", bus.BusReq, 0);
        checkOutput("t6_valid", InsnValid, 0);
        checkOutput("t6_addr", bus.BusAddr, 0);
        checkOutput("t6_fstall", FetchStall, 1);
        checkOutput("t6_insn", Insn, 0);
`ifdef IF_FETCH_PERF_EN
        checkOutput("t6_perf_stall0", PerfStallCnt, 0);
        checkOutput("t6_perf_drop0", PerfDropCnt, 0);
`endif
        reset_ = 1'b0;
        applyStimulus(0, 0, '0, 0, '0, 1, 32'h0000_0BAD);
        step();
        checkOutput("t6_stray_valid", InsnValid, 0);
        checkOutput("t6_req_after", bus.BusReq, 1);
        checkOutput("t6_addr_after", bus.BusAddr, 0);
`ifdef IF_FETCH_PERF_EN
        checkOutput("t6_perf_stall1", PerfStallCnt, 1);
`endif
        applyStimulus(0, 0, '0, 0, '0, 1, mkData(30'h0));
        step();
        checkOutput("t6_valid_after", InsnValid, 1);
        checkOutput("t6_insn_after", Insn, 32'h1000_0000);
        checkOutput("t6_pc_after", InsnPC, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
